qspi_flash_responder: RTL

// Synthesizable W25Q-style quad-IO flash responder: the slave end of the Fast Read Quad I/O (0xEB) link that the
// bus-side memhub initiates. Backs the flash with on-chip ROM/BRAM so that memhub and busrom images can run without a

---
 rtl/qspi_flash_responder.sv | 186 ++++++++++++++++++
 1 files changed

// File: rtl/qspi_flash_responder.sv
// qspi_flash_responder: slave end of a W25Q-style Fast Read Quad I/O (0xEB) link.
// The flash array is backed by an on-chip memory port (mem_addr/mem_rd/mem_rdata).
// Supports continuous-read mode, in which the command byte is skipped on the next frame.
module qspi_flash_responder #(
  parameter int unsigned AW      = 24,
  parameter int unsigned DUMMY   = 4,
  parameter int unsigned MEM_LAT = 1
) (
  input  logic          spiclk,
  input  logic          reset,
  input  logic          ssn,
  input  logic          sck_en,
  input  logic [3:0]    io_in,
  output logic [3:0]    io_out,
  output logic          io_oe,
  output logic [AW-1:0] mem_addr,
  output logic          mem_rd,
  input  logic [7:0]    mem_rdata,
  output logic          cont_mode,
  output logic          busy
);

  // Counter must reach 7 (command bits) and DUMMY-1 (dummy edges).
  localparam int unsigned CNT_W   = (DUMMY > 8) ? $clog2(DUMMY) : 3;
  localparam logic [7:0]  CMD_QIO = 8'hEB;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CMD,
    S_ADDR,
    S_MODE,
    S_DUMMY,
    S_DATA,
    S_IGNORE
  } state_t;

  state_t             state;
  logic [CNT_W-1:0]   cnt;
  logic [6:0]         cmd_sr;
  logic [19:0]        addr_sr;
  logic [1:0]         mode_bits;
  logic [7:0]         pf_byte;
  logic [3:0]         cur_lo;
  logic               lo_next;
  logic [MEM_LAT-1:0] rd_dly;

  logic [7:0]  cmd_full;
  logic [23:0] addr_full;
  logic [7:0]  byte_now;

  assign cmd_full  = {cmd_sr, io_in[0]};
  assign addr_full = {addr_sr, io_in};
  // Read data arriving this very cycle bypasses the prefetch register so a
  // back-to-back high-nibble edge never sees a stale byte.
  assign byte_now  = rd_dly[MEM_LAT-1] ? mem_rdata : pf_byte;

  // Track outstanding reads and capture returning data into the prefetch register.
  always_ff @(posedge spiclk) begin
    if (reset) begin
      rd_dly  <= '0;
      pf_byte <= 8'h00;
    end else begin
      rd_dly[0] <= mem_rd;
      for (int i = 1; i < int'(MEM_LAT); i++) begin
        rd_dly[i] <= rd_dly[i-1];
      end
      if (rd_dly[MEM_LAT-1]) begin
        pf_byte <= mem_rdata;
      end
    end
  end

  // Protocol FSM: advances only on SCK rising edges while selected.
  always_ff @(posedge spiclk) begin
    if (reset) begin
      state     <= S_IDLE;
      cnt       <= '0;
      cmd_sr    <= 7'h00;
      addr_sr   <= 20'h00000;
      mode_bits <= 2'b00;
      cur_lo    <= 4'h0;
      lo_next   <= 1'b0;
      io_out    <= 4'h0;
      io_oe     <= 1'b0;
      mem_addr  <= '0;
      mem_rd    <= 1'b0;
      cont_mode <= 1'b0;
      busy      <= 1'b0;
    end else begin
      mem_rd <= 1'b0;
      if (ssn) begin
        state   <= S_IDLE;
        cnt     <= '0;
        lo_next <= 1'b0;
        io_oe   <= 1'b0;
        busy    <= 1'b0;
      end else if (sck_en) begin
        case (state)
          S_IDLE: begin
            busy <= 1'b1;
            cnt  <= CNT_W'(1);
            if (cont_mode) begin
              addr_sr <= {16'h0000, io_in};
              state   <= S_ADDR;
            end else begin
              cmd_sr <= {6'b000000, io_in[0]};
              state  <= S_CMD;
            end
          end

          S_CMD: begin
            cmd_sr <= {cmd_sr[5:0], io_in[0]};
            if (cnt == CNT_W'(7)) begin
              cnt   <= '0;
              state <= (cmd_full == CMD_QIO) ? S_ADDR : S_IGNORE;
            end else begin
              cnt <= cnt + CNT_W'(1);
            end
          end

          S_ADDR: begin
            if (cnt == CNT_W'(5)) begin
              mem_addr <= AW'(addr_full);
              mem_rd   <= 1'b1;
              cnt      <= '0;
              state    <= S_MODE;
            end else begin
              addr_sr <= {addr_sr[15:0], io_in};
              cnt     <= cnt + CNT_W'(1);
            end
          end

          S_MODE: begin
            if (cnt == '0) begin
              // First mode nibble carries M[7:4]; M[5:4] select continuous read.
              mode_bits <= io_in[1:0];
              cnt       <= CNT_W'(1);
            end else begin
              cont_mode <= (mode_bits == 2'b10);
              cnt       <= '0;
              state     <= S_DUMMY;
            end
          end

          S_DUMMY: begin
            if (cnt == CNT_W'(DUMMY - 1)) begin
              io_oe    <= 1'b1;
              io_out   <= byte_now[7:4];
              cur_lo   <= byte_now[3:0];
              mem_rd   <= 1'b1;
              mem_addr <= mem_addr + AW'(1);
              lo_next  <= 1'b1;
              cnt      <= '0;
              state    <= S_DATA;
            end else begin
              cnt <= cnt + CNT_W'(1);
            end
          end

          S_DATA: begin
            if (lo_next) begin
              io_out  <= cur_lo;
              lo_next <= 1'b0;
            end else begin
              // Loading a new high nibble also prefetches the byte after it.
              io_out   <= byte_now[7:4];
              cur_lo   <= byte_now[3:0];
              mem_rd   <= 1'b1;
              mem_addr <= mem_addr + AW'(1);
              lo_next  <= 1'b1;
            end
          end

          S_IGNORE: begin
            io_oe <= 1'b0;
          end

          default: begin
            state <= S_IDLE;
          end
        endcase
      end
    end
  end

endmodule
